uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Parametrised multi-channel byte scheduler that feeds the UART transmit path toward GenshinKitchen. Game-state, target-machine and operate-machine producers each post bytes on their own request channel. The block holds one pending byte per channel, coalesces repeated requests, and arbitrates round-robin. It presents exactly one byte at a time to the UART, advancing only on the UART's byte-complete pulse. It replaces single-source send logic and adds a hold mode and a stall watchdog.

## Interface
- N_CH, 4: number of request channels (2..8)
- DATA_W, 8: byte width (fixed to the UART frame)
- IDLE_BYTE, 8'h00: byte presented when nothing is scheduled
- TIMEOUT, 65535: cycles without tx_ready while BUSY before stall asserts (≥2)

- clock  in  1  UART 16x clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req_valid  in  N_CH  one-cycle pulse per channel: load req_data slice into that channel's slot
- req_data  in  N_CH*DATA_W  channel i byte at bits [i*8+7:i*8]
- hold  in  1  1 = grant nothing; IDLE_BYTE is scheduled on the next completion
- tx_ready  in  1  UART pulse: current byte finished transmitting
- tx_bits  out  DATA_W  registered byte presented to UART (io_dataIn_bits)
- pending  out  N_CH  slot-full flags
- sent  out  N_CH  one-hot, one-cycle pulse: that channel's byte completed
- overwrite  out  N_CH  sticky: a pending byte was replaced before being granted
- stall  out  1  watchdog: TIMEOUT cycles in BUSY with no tx_ready

## Operation
- Reset values: tx_bits=IDLE_BYTE, pending=0, sent=0, overwrite=0, stall=0, state=IDLE, rr pointer=0 (channel 0 highest priority), watchdog=0.
- Slot write: req_valid[i]=1 loads slot i and sets pending[i]. If pending[i] was already 1 and slot i is not granted that cycle, the old byte is lost and overwrite[i] sets. overwrite clears only on reset.
- States:
  - IDLE: tx_bits=IDLE_BYTE, no channel owns the line.
  - BUSY(c): tx_bits=slot byte of channel c, latched at grant.
- Advance happens only on a cycle with tx_ready=1.
  - If BUSY(c): sent[c] pulses on the following cycle.
  - Then grant: if hold=0 and any pending bit is set, pick the first set bit searching from rr pointer upward with wrap. Copy the slot to tx_bits, clear pending[g], set rr pointer to (g+1) mod N_CH, state BUSY(g).
  - Otherwise tx_bits=IDLE_BYTE and state IDLE; rr pointer unchanged.
- Eligibility uses registered pending only. A req_valid arriving on an empty slot in the same cycle as tx_ready is not eligible until the next tx_ready.
- Simultaneous req_valid[i] and grant of i: the old byte is granted, the new byte stays pending (pending[i] remains 1), and overwrite[i] does not set.
- tx_ready while IDLE with nothing pending: no sent pulse, tx_bits stays IDLE_BYTE.
- hold asserted while BUSY: the in-flight byte still completes and sent still pulses; pending slots are retained.
- Watchdog: counts clock cycles in BUSY since the last tx_ready, saturating at TIMEOUT. stall=1 while the count equals TIMEOUT. The counter clears on tx_ready and holds at 0 in IDLE. stall never drops bytes.

## Timing
- tx_bits, pending, sent, state update on the clock edge where tx_ready=1; new values are visible the next cycle.
- sent is registered: it rises one cycle after the tx_ready that completed the byte and lasts exactly one cycle.
- Minimum request-to-line latency: req_valid at cycle t, then tx_ready at t+1 or later, then tx_bits valid the cycle after that tx_ready.
- Asynchronous reset asserted mid-byte: the line returns to IDLE_BYTE at once and the in-flight byte gets no sent pulse. Release is synchronous-safe; the first action after release is a grant on the next tx_ready.

## Test plan
- Reset: assert reset mid-BUSY with pending=4'b1010 -> tx_bits=8'h00, pending=0, sent=0, overwrite=0, stall=0 immediately.
- Single channel: req_valid=4'b0100, byte 8'h35; tx_ready -> tx_bits=8'h35, pending=0. Second tx_ready -> sent=4'b0100 one cycle, tx_bits=8'h00.
- Round-robin: all four post 8'hA0..8'hA3 together, then five tx_ready pulses -> tx_bits sequence A0, A1, A2, A3, 00 and sent 0001, 0010, 0100, 1000. A new ch0 request then wins after ch3.
- Coalesce/coincide:
  - ch1 posts 8'h11 then 8'h22 before any tx_ready -> 8'h22 sent, overwrite[1]=1.
  - ch2 request coincident with grant of ch2 -> old byte sent, new byte pending, overwrite[2]=0.
- Hold: pending=4'b0011, hold=1, three tx_ready -> tx_bits stays 8'h00 and pending unchanged. hold=0 plus tx_ready -> ch0 granted.
- Watchdog with TIMEOUT=16: grant, then no tx_ready -> stall=1 on the 16th BUSY cycle after grant. It stays high, and the next tx_ready clears stall and advances normally.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Multi-channel byte scheduler in front of the UART transmit path. Each
//   request channel owns a one-byte slot. A new request to a full slot replaces
//   the old byte. Full slots are granted round-robin, one byte at a time, and
//   the scheduler advances only on the UART byte-complete pulse (tx_ready).
//
// Ports
//   clock      : UART 16x clock, all logic on the rising edge
//   reset      : asynchronous, active-low
//   req_valid  : per-channel one-cycle load strobe
//   req_data   : channel i byte at [i*DATA_W +: DATA_W]
//   hold       : 1 = grant nothing on the next completion (line goes idle)
//   tx_ready   : UART pulse, the byte on tx_bits has finished
//   tx_bits    : registered byte presented to the UART
//   pending    : slot-full flags
//   sent       : one-hot, one-cycle pulse for the channel whose byte completed
//   overwrite  : sticky, a pending byte was replaced before it was granted
//   stall      : watchdog, TIMEOUT cycles in BUSY with no tx_ready
//   dbgState   : current FSM state (0 = IDLE, 1 = BUSY)
//   dbgOwner   : channel that owns the line while BUSY
//
// Handshake: there is no backpressure toward the producers. A req_valid pulse
// is always accepted into its slot. Toward the UART, tx_bits is stable from one
// tx_ready pulse to the next. Each tx_ready consumes the byte in flight and
// selects the next one.
module uart_tx_scheduler #(
  parameter int                N_CH      = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = 8'h00,
  parameter int                TIMEOUT   = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  input  logic                     hold,
  input  logic                     tx_ready,
  output logic [DATA_W-1:0]        tx_bits,
  output logic [N_CH-1:0]          pending,
  output logic [N_CH-1:0]          sent,
  output logic [N_CH-1:0]          overwrite,
  output logic                     stall,
  output logic                     dbgState,
  output logic [$clog2(N_CH)-1:0]  dbgOwner
);

  localparam int CH_W = $clog2(N_CH);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state;
  logic [CH_W-1:0]        owner;
  logic [CH_W-1:0]        rrPtr;
  logic [WD_W-1:0]        wdCount;
  logic [DATA_W-1:0]      slots [N_CH];

  logic                   grantValid;
  logic [CH_W-1:0]        grantIdx;
  logic                   doGrant;

  // First full slot at or above rrPtr, wrapping. Uses registered pending only,
  // so a request landing in the same cycle is not yet eligible.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grantValid && pending[(int'(rrPtr) + k) % N_CH]) begin
        grantValid = 1'b1;
        grantIdx   = CH_W'((int'(rrPtr) + k) % N_CH);
      end
    end
  end

  assign doGrant  = tx_ready && !hold && grantValid;
  assign dbgState = state;
  assign dbgOwner = owner;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      rrPtr     <= '0;
      wdCount   <= '0;
      tx_bits   <= IDLE_BYTE;
      pending   <= '0;
      sent      <= '0;
      overwrite <= '0;
      stall     <= 1'b0;
      for (int i = 0; i < N_CH; i++) slots[i] <= '0;
    end else begin
      sent <= '0;

      if (tx_ready) begin
        if (state == BUSY) sent[owner] <= 1'b1;
        if (doGrant) begin
          state   <= BUSY;
          owner   <= grantIdx;
          tx_bits <= slots[grantIdx];
          rrPtr   <= (grantIdx == CH_W'(N_CH - 1)) ? '0 : grantIdx + 1'b1;
          // Counts BUSY cycles including the current one, so the first
          // cycle after grant already reads 1.
          wdCount <= WD_W'(1);
        end else begin
          state   <= IDLE;
          tx_bits <= IDLE_BYTE;
          wdCount <= '0;
        end
        stall <= 1'b0;
      end else if (state == BUSY && wdCount != WD_W'(TIMEOUT)) begin
        wdCount <= wdCount + 1'b1;
        stall   <= (wdCount == WD_W'(TIMEOUT - 1));
      end

      // A slot granted this cycle hands its old byte to the line. A request
      // arriving in the same cycle refills it without counting as a loss.
      for (int i = 0; i < N_CH; i++) begin
        if (req_valid[i]) begin
          slots[i]   <= req_data[i*DATA_W +: DATA_W];
          pending[i] <= 1'b1;
          if (pending[i] && !(doGrant && grantIdx == CH_W'(i)))
            overwrite[i] <= 1'b1;
        end else if (doGrant && grantIdx == CH_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam logic [W-1:0] IDLE = 8'h00;

  // ---------------- clock / reset ----------------
  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           hold;
  logic           tx_ready;
  logic [W-1:0]   tx_bits;
  logic [N-1:0]   pending;
  logic [N-1:0]   sent;
  logic [N-1:0]   overwrite;
  logic           stall;
  logic           dbgState;
  logic [1:0]     dbgOwner;

  always #5 clock = ~clock;

  uart_tx_scheduler #(
    .N_CH(N), .DATA_W(W), .IDLE_BYTE(IDLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .hold(hold), .tx_ready(tx_ready), .tx_bits(tx_bits), .pending(pending),
    .sent(sent), .overwrite(overwrite), .stall(stall),
    .dbgState(dbgState), .dbgOwner(dbgOwner)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots, a line owner (-1 = idle), a round-robin start point and a count of
  // BUSY cycles. The rules are applied directly at each rising edge.
  logic [W-1:0] mSlot [N];
  bit           mPend [N];
  bit           mOw   [N];
  int           mOwner = -1;
  int           mRr = 0;
  int           mCnt = 0;
  logic [W-1:0] mTx = IDLE;
  logic [N-1:0] mSent = '0;

  always @(posedge clock or negedge reset) begin : model
    int g;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin mSlot[i] = '0; mPend[i] = 0; mOw[i] = 0; end
      mOwner = -1; mRr = 0; mCnt = 0; mTx = IDLE; mSent = '0;
    end else begin
      g = -1;
      mSent = '0;
      if (tx_ready) begin
        if (mOwner >= 0) mSent[mOwner] = 1'b1;
        if (!hold)
          for (int k = 0; k < N; k++)
            if (g < 0 && mPend[(mRr + k) % N]) g = (mRr + k) % N;
        if (g >= 0) begin
          mTx = mSlot[g]; mRr = (g + 1) % N; mCnt = 1; mPend[g] = 0;
        end else begin
          mTx = IDLE; mCnt = 0;
        end
        mOwner = g;
      end else if (mOwner >= 0 && mCnt < TIMEOUT) begin
        mCnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (mPend[i]) mOw[i] = 1;
          mSlot[i] = req_data[i*W +: W];
          mPend[i] = 1;
        end
      end
    end
  end

  function automatic logic [N-1:0] packBits(input bit b [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = b[i];
    return r;
  endfunction

  // ---------------- scoreboard: compare every cycle ----------------
  // Expected line bytes queue up at each tx_ready and are checked in order.
  logic [W-1:0] exp_q[$];
  always @(posedge clock) if (reset && tx_ready) exp_q.push_back(mTx);

  always @(negedge clock) begin
    chk("tx_bits", 32'(tx_bits), 32'(mTx));
    chk("pending", 32'(pending), 32'(packBits(mPend)));
    chk("sent", 32'(sent), 32'(mSent));
    chk("overwrite", 32'(overwrite), 32'(packBits(mOw)));
    chk("stall", 32'(stall), 32'(mCnt == TIMEOUT));
    while (exp_q.size() > 0) chk("line_queue", 32'(tx_bits), 32'(exp_q.pop_front()));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] rv, input logic [N*W-1:0] d,
                      input logic h, input logic txr);
    @(posedge clock);
    #1;
    req_valid = rv; req_data = d; hold = h; tx_ready = txr;
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock); #2;
    reset = 1'b1;
  endtask

  logic [W-1:0] rrSeq [5];
  logic [N-1:0] rrSent [5];

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; hold = 1'b0; tx_ready = 1'b0;
    rrSeq  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    rrSent = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    #12 reset = 1'b1;

    // single channel
    step(4'b0100, 32'h0035_0000, 0, 0);
    step('0, '0, 0, 1);
    idle();
    chk("single_tx", 32'(tx_bits), 32'h35);
    chk("single_pend", 32'(pending), 32'h0);
    step('0, '0, 0, 1);
    idle();
    chk("single_sent", 32'(sent), 32'b0100);
    chk("single_idle", 32'(tx_bits), 32'h00);

    // round robin from a fresh pointer
    doReset();
    step(4'b1111, 32'hA3A2_A1A0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step('0, '0, 0, 1);
      idle();
      chk("rr_tx", 32'(tx_bits), 32'(rrSeq[k]));
      chk("rr_sent", 32'(sent), 32'(rrSent[k]));
    end
    step(4'b0101, 32'h005C_005A, 0, 0);
    step('0, '0, 0, 1);
    idle();
    chk("rr_wrap_ch0", 32'(tx_bits), 32'h5A);

    // coalesce
    doReset();
    step(4'b0010, 32'h0000_1100, 0, 0);
    step(4'b0010, 32'h0000_2200, 0, 0);
    step('0, '0, 0, 1);
    idle();
    chk("coal_tx", 32'(tx_bits), 32'h22);
    chk("coal_ow", 32'(overwrite), 32'b0010);
    step('0, '0, 0, 1);
    idle();
    chk("coal_sent", 32'(sent), 32'b0010);

    // request coincident with grant of the same channel
    step(4'b0100, 32'h0044_0000, 0, 0);
    step(4'b0100, 32'h0055_0000, 0, 1);
    idle();
    chk("coin_tx", 32'(tx_bits), 32'h44);
    chk("coin_pend", 32'(pending), 32'b0100);
    chk("coin_ow", 32'(overwrite), 32'b0010);
    step('0, '0, 0, 1);
    idle();
    chk("coin_sent", 32'(sent), 32'b0100);
    chk("coin_next", 32'(tx_bits), 32'h55);

    // hold
    doReset();
    step(4'b0011, 32'h0000_C1C0, 0, 0);
    for (int k = 0; k < 3; k++) step('0, '0, 1, 1);
    step('0, '0, 1, 0);
    chk("hold_tx", 32'(tx_bits), 32'h00);
    chk("hold_pend", 32'(pending), 32'b0011);

    // release hold, then watchdog with no tx_ready
    step('0, '0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (k == 1) chk("hold_grant", 32'(tx_bits), 32'hC0);
      chk("wd_stall", 32'(stall), 32'(k >= TIMEOUT));
    end
    step('0, '0, 0, 1);
    idle();
    chk("wd_clear", 32'(stall), 32'h0);
    chk("wd_next", 32'(tx_bits), 32'hC1);
    chk("wd_sent", 32'(sent), 32'b0001);

    // asynchronous reset mid-byte
    step(4'b1010, 32'h7700_6600, 0, 0);
    idle();
    chk("pre_rst_pend", 32'(pending), 32'b1010);
    #2 reset = 1'b0;
    #1;
    chk("rst_tx", 32'(tx_bits), 32'h00);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_sent", 32'(sent), 32'h0);
    chk("rst_ow", 32'(overwrite), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    @(negedge clock); #2 reset = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] rv;
      int slowTx;
      slowTx = ((n / 400) % 2 == 1);
      for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 5) == 0);
      step(rv, {$urandom()}, ($urandom_range(0, 7) == 0),
           slowTx ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0));
      if (n == 1500) begin
        #3 reset = 1'b0;
        @(negedge clock); #2 reset = 1'b1;
      end
    end
    idle();
    repeat (3) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
